// File: rtl/issue_pkg.sv
// issue_pkg: opcodes, NOP encoding and RV32 field helpers for the dual-issue queue
package issue_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  function automatic logic [4:0] rd_of(input logic [31:0] i);
    return i[11:7];
  endfunction
  function automatic logic [4:0] rs1_of(input logic [31:0] i);
    return i[19:15];
  endfunction
  function automatic logic [4:0] rs2_of(input logic [31:0] i);
    return i[24:20];
  endfunction
  function automatic logic writes_rd(input logic [31:0] i);
    return i[6:0] != OP_STORE && i[6:0] != OP_BRANCH;
  endfunction
endpackage

// File: rtl/issue_queue_if.sv
// issue_queue_if: fetch-side handshake and issue-side outputs of the issue queue
interface issue_queue_if #(parameter int DEPTH = 4, parameter int XLEN = 32);
  logic fetch_valid, fetch_pair, fetch_ready, freeze, flush;
  logic [XLEN-1:0] fetch_ins0, fetch_ins1, instruction0, instruction1;
  logic datapath_1_enable, datapath_2_enable;
  logic [$clog2(DEPTH):0] queue_count;
  modport master(output fetch_valid, fetch_pair, fetch_ins0, fetch_ins1, freeze, flush,
                 input fetch_ready, instruction0, instruction1, datapath_1_enable,
                 datapath_2_enable, queue_count);
  modport slave(input fetch_valid, fetch_pair, fetch_ins0, fetch_ins1, freeze, flush,
                output fetch_ready, instruction0, instruction1, datapath_1_enable,
                datapath_2_enable, queue_count);
endinterface

// File: rtl/issue_queue_pair_check.sv
// pair_check: decides whether the head+1 instruction may issue alongside the head
module pair_check
  import issue_pkg::*;
(
  input  logic [31:0] ins0,
  input  logic [31:0] ins1,
  output logic        pair_ok
);
  logic ctrl, raw, waw, mem_pair, unused_bits;
  always_comb begin
    ctrl = ins0[6:0] == OP_BRANCH || ins0[6:0] == OP_JAL ||
           ins0[6:0] == OP_JALR || ins0[6:0] == OP_SYSTEM;
    // conservative: rs fields compared whatever the format of ins1
    raw = writes_rd(ins0) && rd_of(ins0) != 5'd0 &&
          (rd_of(ins0) == rs1_of(ins1) || rd_of(ins0) == rs2_of(ins1));
    waw = writes_rd(ins0) && writes_rd(ins1) && rd_of(ins0) != 5'd0 &&
          rd_of(ins0) == rd_of(ins1);
    mem_pair = (ins0[6:0] == OP_LOAD || ins0[6:0] == OP_STORE) &&
               (ins1[6:0] == OP_LOAD || ins1[6:0] == OP_STORE);
    pair_ok = !(ctrl || raw || waw || mem_pair);
  end
  assign unused_bits = ^{ins0[31:12], ins1[31:25], ins1[14:12]};
endmodule

// File: rtl/issue_queue.sv
// issue_queue: circular instruction buffer issuing up to two instructions per cycle
module issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic       clk,
  input logic       rst_pin,
  issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, enq, deq;
  logic [XLEN-1:0] head, nxt;
  logic pair_ok, accept, issue1, issue2;
  assign head = mem[rd_ptr];
  assign nxt  = mem[rd_ptr + AW'(1)];
  pair_check u_pair (.ins0(head), .ins1(nxt), .pair_ok(pair_ok));
  always_comb begin
    bus.fetch_ready = count <= CW'(DEPTH - 2) && rst_pin;
    bus.queue_count = count;
    accept = bus.fetch_valid && bus.fetch_ready && !bus.flush;
    enq = accept ? (bus.fetch_pair ? CW'(2) : CW'(1)) : '0;
    // issue decision sees pre-edge count only: no fetch-to-issue bypass
    issue1 = !bus.freeze && count != '0;
    issue2 = issue1 && count >= CW'(2) && pair_ok;
    deq = CW'(issue1) + CW'(issue2);
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= bus.fetch_ins0;
      if (bus.fetch_pair) mem[wr_ptr + AW'(1)] <= bus.fetch_ins1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_pin || bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      bus.instruction0 <= XLEN'(NOP_INSTR);
      bus.instruction1 <= XLEN'(NOP_INSTR);
      bus.datapath_1_enable <= 1'b0;
      bus.datapath_2_enable <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + enq[AW-1:0];
      rd_ptr <= rd_ptr + deq[AW-1:0];
      count <= count + enq - deq;
      if (!bus.freeze) begin
        bus.instruction0 <= issue1 ? head : XLEN'(NOP_INSTR);
        bus.instruction1 <= issue2 ? nxt : XLEN'(NOP_INSTR);
        bus.datapath_1_enable <= issue1;
        bus.datapath_2_enable <= issue2;
      end
    end
  end
endmodule

// File: doc/issue_queue.md
# issue_queue

Dual-issue instruction queue between instruction-cache fetch and the two datapaths. Accepts one or two instructions per cycle from fetch, buffers them in a small circular queue, and every cycle issues up to two in program order to datapath 1 and datapath 2. Slot 2 issues only if the head pair passes the pairing check. Replaces ad-hoc pairing logic at the top level; its outputs drive the `instruction0`, `instruction1` and `datapath_N_enable` nets.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥ 4
- `XLEN`, 32: instruction width
- `clk`  in  1  system clock
- `rst_pin`  in  1  reset; synchronous, active-low
- `fetch_valid`  in  1  fetch presents instructions this cycle
- `fetch_pair`  in  1  1: both `fetch_ins0` and `fetch_ins1` valid; 0: only `fetch_ins0`
- `fetch_ins0`  in  XLEN  older fetched instruction
- `fetch_ins1`  in  XLEN  younger fetched instruction
- `fetch_ready`  out  1  queue can accept two entries
- `freeze`  in  1  back-end stall; no issue this cycle
- `flush`  in  1  taken branch/redirect; discard all queued and issued state
- `instruction0`  out  XLEN  issued instruction, datapath 1
- `instruction1`  out  XLEN  issued instruction, datapath 2
- `datapath_1_enable`  out  1  `instruction0` valid
- `datapath_2_enable`  out  1  `instruction1` valid
- `queue_count`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer with head pointer `rd_ptr` and tail pointer `wr_ptr`, both $clog2(DEPTH) bits, wrapping mod DEPTH. Occupancy `count` is explicit.
- `fetch_ready` = (`count` ≤ DEPTH-2) && `rst_pin`. It is combinational from registered state only.
- Enqueue: when `fetch_valid` && `fetch_ready`, write `fetch_ins0` at `wr_ptr`. If `fetch_pair`, also write `fetch_ins1` at `wr_ptr+1`. `enq` = 1 or 2.
- When `fetch_valid` && !`fetch_ready`, fetch data is ignored. Fetch must hold its data until accepted.
- Issue register: `instruction0/1` and both enables are registered. On each edge with !`freeze`:
  - `count` = 0: load NOP (32'h00000013) into both slots, enables 0, `deq` = 0.
  - `count` ≥ 1: slot 1 = head entry, `datapath_1_enable` = 1.
  - Slot 2 = head+1 entry with `datapath_2_enable` = 1 only if `count` ≥ 2 and pair_ok. Otherwise slot 2 gets NOP with enable 0.
  - `deq` = number of enables set.
- pair_ok is false if any of the following holds for ins0 (head) and ins1 (head+1):
  - ins0 opcode is BRANCH (1100011), JAL (1101111), JALR (1100111) or SYSTEM (1110011).
  - ins0 writes a register (opcode is not STORE or BRANCH), its rd ≠ 0, and rd equals ins1 [19:15] or ins1 [24:20]. This check is conservative and applies regardless of ins1 format.
  - Both instructions write registers and share the same nonzero rd (WAW).
  - Both are LOAD (0000011) or STORE (0100011) in any combination.
- `freeze` high: issue registers hold their values, `deq` = 0, and enqueue proceeds normally.
- `flush` high, with priority over fetch, freeze and issue: `count`, `rd_ptr` and `wr_ptr` are cleared, both slots are loaded with NOP, and enables go to 0. Nothing is enqueued that cycle.
- Count update: `count_next` = `count` + `enq` − `deq`. Simultaneous enqueue and dequeue is legal. The dequeue decision uses pre-edge `count`, so no bypass from fetch to issue occurs in the same edge.

## Timing
- Reset (`rst_pin` = 0 at an edge): `instruction0/1` = 32'h00000013, enables 0, `queue_count` 0, pointers 0. `fetch_ready` is 0 while `rst_pin` is low.
- Fetch-to-issue latency is 2 edges. Data accepted at edge N is in the queue after N and appears on the outputs after N+1, provided it is at the head and `freeze` is low.
- Throughput: 2 instructions per cycle when pairs pass pair_ok and fetch keeps up.
- Full: `count` ∈ {DEPTH-1, DEPTH} forces `fetch_ready` low. `count` never exceeds DEPTH.
- Pointer wrap from DEPTH-1 to 0 is seamless, including a pair write that straddles the wrap.
- Reset or flush mid-stream: state is empty on the following cycle, and fetch may enqueue on the next edge.

## Structure
- Package `issue_pkg`:
  - Opcode localparams: OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM.
  - `NOP_INSTR`.
  - Field-extract functions `rd_of`, `rs1_of`, `rs2_of`, `writes_rd`.
- Sub-module `pair_check`: purely combinational. Inputs ins0/ins1; output `pair_ok`.
- `issue_queue` contains the storage, pointers, count and issue registers.

## Test plan
- Reset held 3 cycles → outputs NOP/NOP, enables 0, `fetch_ready` 0; after release `fetch_ready` 1 and `queue_count` 0.
- Pair 00500093/00700113 accepted at edge N → after N+1, `instruction0`=00500093 and `instruction1`=00700113, both enables 1, `queue_count` 0.
- RAW: pair 00500093/002081B3 → first issue 00500093 with enable1 only. Next cycle `instruction0`=002081B3, enable1 1, enable2 0.
- Serialisation cases:
  - Pair 00002203/00402223 (lw/sw) issues one per cycle.
  - Pair 00000463/00500093 (beq first) issues beq alone.
- Full: `freeze`=1 with two pairs enqueued → `queue_count` 4, `fetch_ready` 0, and a third `fetch_valid` is ignored. Release `freeze` → drains in 2 cycles and `fetch_ready` returns.
- Flush asserted with `fetch_valid`=1 and `count`=3 → next cycle `queue_count` 0, NOP outputs, enables 0, and the fetched data is not enqueued.
